// File: rtl/acoustic_cam_top.sv
// Acoustic camera front end: I2S clocking/sampling of seven mics and sign-correlation lag search for pairs mic0-mic1/3/5.
// Build option XC_CONTINUOUS_EN: back-to-back runs with a one-cycle PAD_DONE pulse per result.
module acoustic_cam_top #(
  parameter int MIC_DIV = 16,
  parameter int NFRAMES = 1024,
  parameter int MAXLAG  = 8
) (
  input  logic       PAD_CLK,
  input  logic       PAD_RST_N,
  input  logic       PAD_XC_EN,
  input  logic       PAD_MIC0_DA,
  input  logic       PAD_MIC12_DA,
  input  logic       PAD_MIC34_DA,
  input  logic       PAD_MIC56_DA,
  output logic       PAD_WS,
  output logic       PAD_CLK_MIC,
  output logic       PAD_DONE,
  output logic [4:0] PAD_LAG_A,
  output logic [4:0] PAD_LAG_B,
  output logic [4:0] PAD_LAG_C
);

  // state  | meaning
  // S_IDLE | PAD_XC_EN high: accumulators, frame counter, shift registers cleared
  // S_RUN  | counting frames: first 2*MAXLAG fill taps, next NFRAMES accumulate
  // S_SCAN | argmax over all lags, one lag per cycle, highest index first
  // S_DONE | result valid (held, or single-cycle in continuous mode)
  typedef enum logic [1:0] {S_IDLE, S_RUN, S_SCAN, S_DONE} state_t;

  localparam int HALF  = MIC_DIV / 2;
  localparam int DIV_W = $clog2(HALF);
  localparam int NTAP  = 2 * MAXLAG + 1;
  localparam int NRUN  = 2 * MAXLAG + NFRAMES;
  localparam int FRM_W = $clog2(NRUN + 1);
  localparam int TAP_W = $clog2(NTAP);
  localparam logic [DIV_W-1:0] DIV_LOAD = DIV_W'(HALF - 1);
  localparam logic [FRM_W-1:0] FRM_LOAD = FRM_W'(NRUN);
  localparam logic [FRM_W-1:0] FRM_ACC  = FRM_W'(NFRAMES);
  localparam logic [TAP_W-1:0] TAP_LAST = TAP_W'(NTAP - 1);
  localparam logic [10:0]      ACC_MAX  = 11'h7FF;

  state_t             state, state_nxt;
  logic               xc_meta, xc_sync;
  logic [DIV_W-1:0]   div_cnt;
  logic               clk_mic, ws, mic_fall, frame_tick;
  logic [4:0]         bit_cnt;
  logic               s0_smp;
  logic [2:0]         sx_smp;
  logic [MAXLAG:0]    s0_sr;
  logic [NTAP-1:0]    xsr [3];
  logic [10:0]        acc [3][NTAP];
  logic [FRM_W-1:0]   frm_left;
  logic               acc_pend, last_pend;
  logic [TAP_W-1:0]   scan_cnt;
  logic [10:0]        best_val [3];
  logic [TAP_W-1:0]   best_idx [3];
  logic [TAP_W-1:0]   fin_idx  [3];
  logic [4:0]         lag      [3];
  logic               done;

  assign PAD_CLK_MIC = clk_mic;
  assign PAD_WS      = ws;
  assign PAD_DONE    = done;
  assign PAD_LAG_A   = lag[0];
  assign PAD_LAG_B   = lag[1];
  assign PAD_LAG_C   = lag[2];

  always_ff @(posedge PAD_CLK or negedge PAD_RST_N)
    if (!PAD_RST_N) {xc_sync, xc_meta} <= 2'b11;
    else            {xc_sync, xc_meta} <= {xc_meta, PAD_XC_EN};

  always_ff @(posedge PAD_CLK or negedge PAD_RST_N)
    if (!PAD_RST_N) begin
      div_cnt <= DIV_LOAD;
      clk_mic <= 1'b0;
    end else if (div_cnt == '0) begin
      div_cnt <= DIV_LOAD;
      clk_mic <= ~clk_mic;
    end else begin
      div_cnt <= div_cnt - 1'b1;
    end

  assign mic_fall   = (div_cnt == '0) && clk_mic;
  assign frame_tick = mic_fall && (bit_cnt == 5'd31) && ws;

  // bit_cnt==1 at a falling edge is slot bit 2, the MSB after the one-bit I2S delay
  always_ff @(posedge PAD_CLK or negedge PAD_RST_N)
    if (!PAD_RST_N) begin
      bit_cnt <= '0;
      ws      <= 1'b0;
      s0_smp  <= 1'b0;
      sx_smp  <= '0;
    end else if (mic_fall) begin
      bit_cnt <= bit_cnt + 5'd1;
      if (bit_cnt == 5'd31) ws <= ~ws;
      if (bit_cnt == 5'd1) begin
        if (ws) s0_smp <= PAD_MIC0_DA;
        else    sx_smp <= {PAD_MIC56_DA, PAD_MIC34_DA, PAD_MIC12_DA};
      end
    end

  always_ff @(posedge PAD_CLK or negedge PAD_RST_N)
    if (!PAD_RST_N) state <= S_IDLE;
    else            state <= state_nxt;

  always_comb begin
    state_nxt = state;
    if (xc_sync) begin
      state_nxt = S_IDLE;
    end else begin
      case (state)
        S_IDLE: state_nxt = S_RUN;
        S_RUN:  if (last_pend) state_nxt = S_SCAN;
        S_SCAN: if (scan_cnt == '0) state_nxt = S_DONE;
        S_DONE: begin
`ifdef XC_CONTINUOUS_EN
          state_nxt = S_RUN;
`else
          state_nxt = S_DONE;
`endif
        end
        default: state_nxt = S_IDLE;
      endcase
    end
  end

  // ties resolve to the lowest index (most negative lag) because the scan runs downward with >=
  always_comb begin
    for (int p = 0; p < 3; p++) begin
      fin_idx[p] = best_idx[p];
      if (acc[p][0] >= best_val[p]) fin_idx[p] = '0;
    end
  end

  always_ff @(posedge PAD_CLK or negedge PAD_RST_N)
    if (!PAD_RST_N) begin
      s0_sr     <= '0;
      frm_left  <= FRM_LOAD;
      acc_pend  <= 1'b0;
      last_pend <= 1'b0;
      scan_cnt  <= TAP_LAST;
      done      <= 1'b0;
      for (int p = 0; p < 3; p++) begin
        xsr[p]      <= '0;
        best_val[p] <= '0;
        best_idx[p] <= '0;
        lag[p]      <= '0;
        for (int i = 0; i < NTAP; i++) acc[p][i] <= '0;
      end
    end else begin
      acc_pend  <= 1'b0;
      last_pend <= 1'b0;
      case (state)
        S_IDLE: begin
          s0_sr    <= '0;
          frm_left <= FRM_LOAD;
          done     <= 1'b0;
          for (int p = 0; p < 3; p++) begin
            xsr[p] <= '0;
            for (int i = 0; i < NTAP; i++) acc[p][i] <= '0;
          end
        end
        S_RUN: begin
          scan_cnt <= TAP_LAST;
          for (int p = 0; p < 3; p++) begin
            best_val[p] <= '0;
            best_idx[p] <= '0;
          end
          if (frame_tick) begin
            s0_sr     <= {s0_sr[MAXLAG-1:0], s0_smp};
            frm_left  <= frm_left - 1'b1;
            acc_pend  <= (frm_left <= FRM_ACC);
            last_pend <= (frm_left == FRM_W'(1));
            for (int p = 0; p < 3; p++) xsr[p] <= {xsr[p][NTAP-2:0], sx_smp[p]};
          end
          // taps now hold sX[n-j]; index i pairs s0[n-MAXLAG] with sX[n-2*MAXLAG+i], lag i-MAXLAG
          if (acc_pend) begin
            for (int p = 0; p < 3; p++)
              for (int i = 0; i < NTAP; i++)
                if ((s0_sr[MAXLAG] == xsr[p][2*MAXLAG-i]) && (acc[p][i] != ACC_MAX))
                  acc[p][i] <= acc[p][i] + 11'd1;
          end
        end
        S_SCAN: begin
          scan_cnt <= scan_cnt - 1'b1;
          for (int p = 0; p < 3; p++) begin
            if (acc[p][scan_cnt] >= best_val[p]) begin
              best_val[p] <= acc[p][scan_cnt];
              best_idx[p] <= scan_cnt;
            end
            if (scan_cnt == '0) lag[p] <= 5'(int'(fin_idx[p]) - MAXLAG);
          end
          if (scan_cnt == '0) done <= 1'b1;
        end
        S_DONE: begin
`ifdef XC_CONTINUOUS_EN
          done     <= 1'b0;
          frm_left <= FRM_LOAD;
          for (int p = 0; p < 3; p++)
            for (int i = 0; i < NTAP; i++) acc[p][i] <= '0;
`endif
        end
        default: ;
      endcase
    end

endmodule

// File: tb/tb_acoustic_cam_top.sv
// Scoreboard bench for acoustic_cam_top: bit-level I2S stimulus from random sign patterns,
// expected lags from a direct sign-correlation model, compared by a DONE-edge monitor.
`timescale 1ns/1ps
module tb_acoustic_cam_top;
  localparam int MIC_DIV   = 4;
  localparam int NFRAMES   = 16;
  localparam int MAXLAG    = 8;
  localparam int NRUN      = 2 * MAXLAG + NFRAMES;
  localparam int FRAME_CYC = 64 * MIC_DIV;

  logic       PAD_CLK = 1'b0;
  logic       PAD_RST_N = 1'b0;
  logic       PAD_XC_EN = 1'b1;
  logic       PAD_MIC0_DA = 1'b0, PAD_MIC12_DA = 1'b0, PAD_MIC34_DA = 1'b0, PAD_MIC56_DA = 1'b0;
  logic       PAD_WS, PAD_CLK_MIC, PAD_DONE;
  logic [4:0] PAD_LAG_A, PAD_LAG_B, PAD_LAG_C;

  acoustic_cam_top #(.MIC_DIV(MIC_DIV), .NFRAMES(NFRAMES), .MAXLAG(MAXLAG)) dut (
    .PAD_CLK(PAD_CLK), .PAD_RST_N(PAD_RST_N), .PAD_XC_EN(PAD_XC_EN),
    .PAD_MIC0_DA(PAD_MIC0_DA), .PAD_MIC12_DA(PAD_MIC12_DA),
    .PAD_MIC34_DA(PAD_MIC34_DA), .PAD_MIC56_DA(PAD_MIC56_DA),
    .PAD_WS(PAD_WS), .PAD_CLK_MIC(PAD_CLK_MIC), .PAD_DONE(PAD_DONE),
    .PAD_LAG_A(PAD_LAG_A), .PAD_LAG_B(PAD_LAG_B), .PAD_LAG_C(PAD_LAG_C));

  always #10 PAD_CLK = ~PAD_CLK;

  typedef struct { logic [4:0] a; logic [4:0] b; logic [4:0] c; } exp_t;
  exp_t exp_q[$];
  exp_t last_exp;
  int   n_chk = 0, n_fail = 0;
  bit   sa0[NRUN], sa1[NRUN], sa3[NRUN], sa5[NRUN];

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // best lag k in -MAXLAG..MAXLAG maximising matches of s0[m] against sx[m+k] over the accumulate window
  function automatic logic [4:0] model_lag(input bit s0[NRUN], input bit sx[NRUN]);
    int best, bl, c;
    best = -1; bl = 0;
    for (int k = -MAXLAG; k <= MAXLAG; k++) begin
      c = 0;
      for (int m = MAXLAG; m < MAXLAG + NFRAMES; m++)
        if (s0[m] == sx[m + k]) c++;
      if (c > 2047) c = 2047;
      if (c > best) begin best = c; bl = k; end
    end
    return 5'(bl);
  endfunction

  task automatic gen(input int mode);
    for (int n = 0; n < NRUN; n++) sa0[n] = (mode == 2) ? 1'b0 : 1'($urandom);
    for (int n = 0; n < NRUN; n++) begin
      case (mode)
        0: begin sa1[n] = sa0[n]; sa3[n] = sa0[n]; sa5[n] = sa0[n]; end
        1: begin
          sa1[n] = (n >= 3)       ? sa0[n-3] : 1'($urandom);
          sa3[n] = (n + 2 < NRUN) ? sa0[n+2] : 1'($urandom);
          sa5[n] = (n >= 8)       ? sa0[n-8] : 1'($urandom);
        end
        2: begin sa1[n] = 1'b0; sa3[n] = 1'b0; sa5[n] = 1'b0; end
        default: begin sa1[n] = 1'($urandom); sa3[n] = 1'($urandom); sa5[n] = 1'($urandom); end
      endcase
    end
    last_exp = '{model_lag(sa0, sa1), model_lag(sa0, sa3), model_lag(sa0, sa5)};
  endtask

  task automatic drive_bits(input int j, input logic ws, input int f);
    PAD_MIC0_DA  = (ws && j == 2)  ? sa0[f] : 1'($urandom);
    PAD_MIC12_DA = (!ws && j == 2) ? sa1[f] : 1'($urandom);
    PAD_MIC34_DA = (!ws && j == 2) ? sa3[f] : 1'($urandom);
    PAD_MIC56_DA = (!ws && j == 2) ? sa5[f] : 1'($urandom);
  endtask

  // called at the negedge just after a frame start (WS fall or reset release)
  task automatic drive_run(input int nfr);
    int f, k, cyc;
    logic pm, pw;
    f = 0; k = 0; cyc = 0; pm = PAD_CLK_MIC; pw = PAD_WS;
    drive_bits(1, pw, 0);
    while (f < nfr) begin
      @(negedge PAD_CLK);
      cyc++;
      if (cyc > (nfr + 2) * FRAME_CYC) begin
        chk("drive_frames_timeout", f, nfr);
        break;
      end
      if (pm && !PAD_CLK_MIC) begin
        if (PAD_WS != pw) begin
          k = 0;
          if (!PAD_WS) f++;
          pw = PAD_WS;
        end else begin
          k++;
        end
        if (f < nfr) drive_bits(k + 1, PAD_WS, f);
      end
      pm = PAD_CLK_MIC;
    end
  endtask

  task automatic wait_ws_fall();
    logic pw;
    int c;
    bit ok;
    pw = PAD_WS; c = 0; ok = 0;
    while (c < 2 * FRAME_CYC) begin
      @(negedge PAD_CLK);
      c++;
      if (pw && !PAD_WS) begin ok = 1; break; end
      pw = PAD_WS;
    end
    if (!ok) chk("ws_fall_timeout", 0, 1);
  endtask

  task automatic wait_done();
    int c;
    chk("done_not_early", PAD_DONE, 0);
    c = 0;
    while (!PAD_DONE && c < 100) begin @(negedge PAD_CLK); c++; end
    chk("done_after_run", PAD_DONE, 1);
  endtask

  task automatic run_one(input int mode);
    gen(mode);
    exp_q.push_back(last_exp);
    wait_ws_fall();
    PAD_XC_EN = 1'b0;
    drive_run(NRUN);
    wait_done();
  endtask

  task automatic end_run();
    PAD_XC_EN = 1'b1;
    repeat (8) @(negedge PAD_CLK);
    chk("done_cleared", PAD_DONE, 0);
  endtask

  task automatic meas_period(input bit use_ws, output real per);
    logic prev, cur;
    real t0;
    int rises, c;
    per = 0.0; t0 = 0.0; rises = 0; c = 0;
    prev = use_ws ? PAD_WS : PAD_CLK_MIC;
    while (rises < 2 && c < 4 * FRAME_CYC) begin
      @(posedge PAD_CLK); #1;
      c++;
      cur = use_ws ? PAD_WS : PAD_CLK_MIC;
      if (cur && !prev) begin
        rises++;
        if (rises == 1) t0 = $realtime;
        else per = $realtime - t0;
      end
      prev = cur;
    end
  endtask

  initial begin : monitor
    logic pd;
    exp_t e;
    pd = 1'b0;
    forever begin
      @(negedge PAD_CLK);
      if (PAD_DONE && !pd) begin
        if (exp_q.size() == 0) begin
          n_chk++; n_fail++;
          $display("FAIL unexpected_done: got a result with no run pending, required none");
        end else begin
          e = exp_q.pop_front();
          chk("lag_a", PAD_LAG_A, e.a);
          chk("lag_b", PAD_LAG_B, e.b);
          chk("lag_c", PAD_LAG_C, e.c);
        end
      end
      pd = PAD_DONE;
    end
  end

  initial begin : watchdog
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : stimulus
    real per;
    int n;
    repeat (5) @(negedge PAD_CLK);
    chk("rst_clk_mic", PAD_CLK_MIC, 0);
    chk("rst_ws", PAD_WS, 0);
    chk("rst_done", PAD_DONE, 0);
    chk("rst_lags", {PAD_LAG_A, PAD_LAG_B, PAD_LAG_C}, 0);
    PAD_RST_N = 1'b1;
    n = 0;
    while (n < 50) begin
      @(posedge PAD_CLK); #1;
      n++;
      if (PAD_CLK_MIC) break;
    end
    chk("first_mic_rise", n, MIC_DIV / 2);
    meas_period(1'b0, per);
    chk("mic_period_ns", int'(per), MIC_DIV * 20);
    meas_period(1'b1, per);
    chk("ws_period_ns", int'(per), 64 * MIC_DIV * 20);
    chk("idle_done", PAD_DONE, 0);
    chk("idle_lags", {PAD_LAG_A, PAD_LAG_B, PAD_LAG_C}, 0);

    run_one(0);
    end_run();

    run_one(1);
    wait_ws_fall();
    drive_run(2);
    chk("freeze_done", PAD_DONE, 1);
    chk("freeze_lag_a", PAD_LAG_A, last_exp.a);
    chk("freeze_lag_b", PAD_LAG_B, last_exp.b);
    chk("freeze_lag_c", PAD_LAG_C, last_exp.c);
    end_run();

    run_one(2);
    end_run();
    run_one(3);
    end_run();

    // reset in the middle of a run, enable left asserted
    gen(3);
    wait_ws_fall();
    PAD_XC_EN = 1'b0;
    drive_run(20);
    PAD_RST_N = 1'b0;
    repeat (3) @(negedge PAD_CLK);
    chk("midrst_lags", {PAD_LAG_A, PAD_LAG_B, PAD_LAG_C}, 0);
    chk("midrst_done", PAD_DONE, 0);
    chk("midrst_ws", PAD_WS, 0);
    chk("midrst_clk_mic", PAD_CLK_MIC, 0);
    gen(3);
    exp_q.push_back(last_exp);
    PAD_RST_N = 1'b1;
    drive_run(NRUN);
    wait_done();
    end_run();

    // enable pulsed high for one frame mid-run
    gen(3);
    wait_ws_fall();
    PAD_XC_EN = 1'b0;
    drive_run(12);
    PAD_XC_EN = 1'b1;
    drive_run(1);
    PAD_XC_EN = 1'b0;
    gen(3);
    exp_q.push_back(last_exp);
    drive_run(NRUN);
    wait_done();
    end_run();

    repeat (20) @(negedge PAD_CLK);
    chk("results_outstanding", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
